// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
`timescale 1ns/1ps
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE_I = 2'd1,
    ST_SERVE_D = 2'd2
  } state_t;

  // Access size codes carried on mem_size.
  localparam logic [2:0] SZ_B    = 3'b000;
  localparam logic [2:0] SZ_H    = 3'b001;
  localparam logic [2:0] SZ_W    = 3'b010;
  localparam logic [2:0] SZ_BU   = 3'b100;
  localparam logic [2:0] SZ_HU   = 3'b101;
  localparam logic [2:0] SZ_NONE = 3'b111;

  localparam int STARVE_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 64;

  // 3-bit saturating increment for the starvation counter.
  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'b111) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Combinational grant select: data wins ties until fetch has been passed
// over STARVE_MAX times, then fetch goes first.
`timescale 1ns/1ps
module arb_prio_sel
  import mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic       if_req,
  input  logic       d_req,
  input  logic       mask_i,
  input  logic       mask_d,
  input  logic [2:0] starve_cnt,
  output logic       gnt_i,
  output logic       gnt_d,
  output logic       if_elig
);

  logic d_elig;
  logic starved;

  assign if_elig = if_req & ~mask_i;
  assign d_elig  = d_req & ~mask_d;
  assign starved = (starve_cnt == 3'(STARVE_MAX));
  assign gnt_i   = if_elig & (~d_elig | starved);
  assign gnt_d   = d_elig & ~gnt_i;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single memory controller.
// One transaction in flight; requester fields are captured at grant and the
// memory side is driven only from those holding registers while serving.
`timescale 1ns/1ps
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 17,
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // fetch port
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_ack,
  // data port
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ack,
  // memory controller side
  output logic                  mem_we,
  output logic [2:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  // status
  output logic                  busy,
  output logic                  err
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t                state;
  logic [2:0]            starve_cnt;
  logic [WCW-1:0]        wait_cnt;
  logic                  h_we;
  logic [2:0]            h_size;
  logic [ADDR_WIDTH-1:0] h_addr;
  logic [DATA_WIDTH-1:0] h_wdata;
  logic                  gnt_i, gnt_d, if_elig;
  logic                  hold;
  logic                  srv_i;

  // The ack cycle is a turnaround: neither port is granted in it, so a data
  // requester that re-requests right away competes with fetch on equal
  // footing next cycle and the starvation counter stays meaningful.
  assign hold  = if_ack | d_ack;
  assign srv_i = (state == ST_SERVE_I);

  arb_prio_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .if_req     (if_req),
    .d_req      (d_req),
    .mask_i     (hold),
    .mask_d     (hold),
    .starve_cnt (starve_cnt),
    .gnt_i      (gnt_i),
    .gnt_d      (gnt_d),
    .if_elig    (if_elig)
  );

  // Memory side: holding registers while serving, "no access" otherwise.
  assign busy      = (state != ST_IDLE);
  assign mem_we    = busy & h_we;
  assign mem_size  = busy ? h_size  : SZ_NONE;
  assign mem_addr  = busy ? h_addr  : '0;
  assign mem_wdata = busy ? h_wdata : '0;

  // Arbitration FSM with registered ack/err/read-data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
      h_we       <= 1'b0;
      h_size     <= '0;
      h_addr     <= '0;
      h_wdata    <= '0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      err        <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (gnt_i) begin
            state      <= ST_SERVE_I;
            h_we       <= 1'b0;
            h_size     <= SZ_W;
            h_addr     <= if_addr;
            h_wdata    <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
          end else if (gnt_d) begin
            state    <= ST_SERVE_D;
            h_we     <= d_we;
            h_size   <= d_size;
            h_addr   <= d_addr;
            h_wdata  <= d_wdata;
            wait_cnt <= '0;
            if (if_elig) starve_cnt <= sat_inc3(starve_cnt);
          end
        end
        ST_SERVE_I, ST_SERVE_D: begin
          if (mem_ready) begin
            state <= ST_IDLE;
            if (srv_i) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end
          end else if (wait_cnt == WCW'(TIMEOUT - 1)) begin
            // Controller never answered: complete with zero data and flag it.
            state <= ST_IDLE;
            err   <= 1'b1;
            if (srv_i) begin
              if_rdata <= '0;
              if_ack   <= 1'b1;
            end else begin
              d_rdata <= '0;
              d_ack   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single transactions plus
// hand-written sequences for arbitration order, timeout, ack-cycle masking
// and asynchronous reset.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_pkg::*;

  logic        clk, rst_n;
  logic        if_req;
  logic [16:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req, d_we;
  logic [2:0]  d_size;
  logic [16:0] d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic        d_ack;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        busy, err;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(17), .STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        fetch;
    logic        we;
    logic [2:0]  size;
    logic [16:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          dly;
    logic        e_we;
    logic [2:0]  e_size;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t        tbl[6];
  logic [31:0] last_if, last_d;
  logic [1:0]  got[16];
  int          ng, both, n, bcnt;
  logic        pb;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          fetch we    size    addr       wdata         rdata         dly e_we  e_size  e_wdata
    tbl[0] = '{1'b1, 1'b0, 3'b000, 17'h00040, 32'h00000000, 32'h00500093, 0, 1'b0, 3'b010, 32'h00000000};
    tbl[1] = '{1'b0, 1'b0, 3'b010, 17'h00100, 32'hA5A5A5A5, 32'h12345678, 2, 1'b0, 3'b010, 32'hA5A5A5A5};
    tbl[2] = '{1'b0, 1'b1, 3'b000, 17'h10004, 32'hDEADBEEF, 32'h000000AA, 1, 1'b1, 3'b000, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b0, 3'b101, 17'h1FFFE, 32'h00000000, 32'hFFFF8001, 0, 1'b0, 3'b101, 32'h00000000};
    tbl[4] = '{1'b1, 1'b0, 3'b000, 17'h1FFFC, 32'h00000000, 32'hCAFEF00D, 3, 1'b0, 3'b010, 32'h00000000};
    tbl[5] = '{1'b0, 1'b1, 3'b001, 17'h00000, 32'h0000BEEF, 32'h00000042, 0, 1'b1, 3'b001, 32'h0000BEEF};

    rst_n = 1'b0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_size = '0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 0;
    repeat (3) tick();

    // reset state
    chk("rst_busy", busy, 0);
    chk("rst_mem_size", mem_size, SZ_NONE);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_err", err, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1'b1;
    last_if = '0; last_d = '0;

    // table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      if (tbl[i].fetch) begin
        if_req = 1; if_addr = tbl[i].addr;
        d_req = 0; d_we = 1; d_size = 3'b111; d_wdata = 32'h55555555;
      end else begin
        if_req = 0;
        d_req = 1; d_we = tbl[i].we; d_size = tbl[i].size;
        d_addr = tbl[i].addr; d_wdata = tbl[i].wdata;
      end
      mem_ready = 0;
      tick();
      chk($sformatf("v%0d_busy", i), busy, 1);
      chk($sformatf("v%0d_mem_we", i), mem_we, tbl[i].e_we);
      chk($sformatf("v%0d_mem_size", i), mem_size, tbl[i].e_size);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, tbl[i].e_wdata);
      // requester drops and scribbles its fields; service must continue
      if_req = 0; d_req = 0;
      if_addr = ~tbl[i].addr; d_addr = ~tbl[i].addr;
      d_wdata = ~tbl[i].wdata; d_size = ~tbl[i].size; d_we = ~tbl[i].we;
      for (int k = 0; k < tbl[i].dly; k++) tick();
      chk($sformatf("v%0d_hold_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("v%0d_hold_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_hold_size", i), mem_size, tbl[i].e_size);
      mem_ready = 1; mem_rdata = tbl[i].rdata;
      tick();
      mem_ready = 0; mem_rdata = 32'hBAD0BAD0;
      if (tbl[i].fetch) last_if = tbl[i].rdata; else last_d = tbl[i].rdata;
      chk($sformatf("v%0d_if_ack", i), if_ack, tbl[i].fetch);
      chk($sformatf("v%0d_d_ack", i), d_ack, !tbl[i].fetch);
      chk($sformatf("v%0d_if_rdata", i), if_rdata, last_if);
      chk($sformatf("v%0d_d_rdata", i), d_rdata, last_d);
      chk($sformatf("v%0d_err", i), err, 0);
      chk($sformatf("v%0d_idle_busy", i), busy, 0);
      chk($sformatf("v%0d_idle_size", i), mem_size, SZ_NONE);
      tick();
      chk($sformatf("v%0d_ack_pulse", i), {30'd0, if_ack, d_ack}, 0);
    end

    // both requesters held, memory always ready: D,D,D,D,I,D,D,D,D,I
    if_addr = 17'h00400; d_addr = 17'h00800; d_we = 0; d_size = SZ_W;
    mem_ready = 1; mem_rdata = 32'h0;
    for (int k = 0; k < 16; k++) got[k] = 2'd2;
    ng = 0; pb = 0; both = 0;
    if_req = 1; d_req = 1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (if_ack && d_ack) both++;
      if (busy && !pb && ng < 16) begin
        got[ng] = (mem_addr == 17'h00400) ? 2'd1 : 2'd0;
        ng++;
      end
      pb = busy;
    end
    for (int k = 0; k < 10; k++)
      chk($sformatf("order_%0d", k), got[k], (k == 4 || k == 9) ? 2'd1 : 2'd0);
    chk("no_dual_ack", both, 0);
    if_req = 0; d_req = 0;
    repeat (4) tick();
    mem_ready = 0;
    tick();

    // timeout in SERVE_D
    d_req = 1; d_we = 0; d_size = SZ_W; d_addr = 17'h00100;
    tick();
    chk("to_busy", busy, 1);
    d_req = 0;
    n = 0;
    while (!d_ack && n < 100) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 64);
    chk("to_err", err, 1);
    chk("to_d_rdata", d_rdata, 0);
    chk("to_if_ack", if_ack, 0);
    chk("to_idle", busy, 0);
    d_req = 1;
    tick();
    chk("to_ackcyc_nogrant", busy, 0);
    chk("to_err_pulse", err, 0);
    tick();
    chk("to_regrant", busy, 1);
    d_req = 0; mem_ready = 1; mem_rdata = 32'h00000077;
    tick();
    chk("to_after_ack", d_ack, 1);
    chk("to_after_rdata", d_rdata, 32'h00000077);
    mem_ready = 0;
    tick();

    // d_req held through its ack cycle
    d_req = 1; d_addr = 17'h00300;
    tick();
    chk("hold_grant", busy, 1);
    mem_ready = 1;
    tick();
    chk("hold_ack", d_ack, 1);
    chk("hold_ack_idle", busy, 0);
    tick();
    chk("hold_no_regrant_in_ack", busy, 0);
    tick();
    chk("hold_reserved", busy, 1);
    d_req = 0;
    tick();
    chk("hold_second_ack", d_ack, 1);
    mem_ready = 0;
    tick();

    // asynchronous reset in the middle of SERVE_I
    if_req = 1; if_addr = 17'h00200;
    tick();
    chk("rs_busy", busy, 1);
    chk("rs_size", mem_size, SZ_W);
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("rs_async_size", mem_size, SZ_NONE);
    chk("rs_async_busy", busy, 0);
    mem_ready = 1; if_req = 0;
    tick();
    chk("rs_no_ack0", if_ack, 0);
    tick();
    chk("rs_no_ack1", if_ack, 0);
    chk("rs_if_rdata", if_rdata, 0);
    chk("rs_d_rdata", d_rdata, 0);
    rst_n = 1; if_req = 1; mem_rdata = 32'h0000ABCD;
    tick();
    chk("rs_first_grant", busy, 1);
    if_req = 0;
    tick();
    chk("rs_ack", if_ack, 1);
    chk("rs_rdata", if_rdata, 32'h0000ABCD);
    mem_ready = 0;
    tick();

    // a data request raised and dropped while fetch is served is never served
    if_req = 1; if_addr = 17'h00010;
    tick();
    if_req = 0; d_req = 1;
    tick();
    tick();
    d_req = 0; mem_ready = 1;
    tick();
    chk("drop_if_ack", if_ack, 1);
    mem_ready = 0;
    bcnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy) bcnt++;
    end
    chk("drop_never_served", bcnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
